// File: rtl/iq_frame_collector.sv
// Collects contiguous strobe_cc runs of signed I/Q words into a parallel frame.
// Good-length frames go to a one-deep output register; overflow and bad lengths are counted/flagged.
module iq_frame_collector #(
  parameter int rw = 20,
  parameter int nw = 8,
  parameter int cw = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [rw-1:0] result_iq,
  input  logic                 strobe_cc,
  output logic [nw*rw-1:0]     frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [cw-1:0]        frame_count,
  output logic [cw-1:0]        drop_count,
  output logic                 err_len,
  input  logic                 err_clr
);

  localparam int KW = $clog2(nw + 2);
  localparam logic [KW-1:0] NW_K  = KW'(nw);
  localparam logic [KW-1:0] NW_SAT = KW'(nw + 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                state, state_nxt;
  logic [KW-1:0]         wcnt, wcnt_nxt;
  logic                  wr_en, end_edge, good, bad, load, drop;
  logic signed [rw-1:0]  shadow_p0 [nw];
  logic [nw*rw-1:0]      shadow_flat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    wr_en     = 1'b0;
    end_edge  = 1'b0;
    case (state)
      IDLE: begin
        if (strobe_cc) begin
          state_nxt = CAPTURE;
          wr_en     = 1'b1;
          wcnt_nxt  = KW'(1);
        end
      end
      CAPTURE: begin
        if (strobe_cc) begin
          wr_en    = (wcnt < NW_K);
          wcnt_nxt = (wcnt == NW_SAT) ? wcnt : wcnt + KW'(1);
        end else begin
          end_edge  = 1'b1;
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A frame is good only if exactly nw words arrived; the slot is free if empty or being consumed now
  always_comb begin
    good = end_edge && (wcnt == NW_K);
    bad  = end_edge && (wcnt != NW_K);
    load = good && (!frame_valid || frame_ready);
    drop = good && frame_valid && !frame_ready;
  end

  // Stage p0: shadow capture, word index equals words already received in this run
  always_ff @(posedge clk) begin
    for (int k = 0; k < nw; k++) begin
      if (wr_en && (wcnt == KW'(k))) shadow_p0[k] <= result_iq;
    end
  end

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < nw; k++) shadow_flat[k*rw +: rw] = shadow_p0[k];
  end

  // Stage p1: output frame register and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      err_len     <= 1'b0;
    end else begin
      if (load) begin
        frame_data  <= shadow_flat;
        frame_valid <= 1'b1;
        frame_count <= frame_count + cw'(1);
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      // Same-edge events win over err_clr, so a cleared counter still records this drop
      if (drop)         drop_count <= (err_clr ? '0 : drop_count) + cw'(1);
      else if (err_clr) drop_count <= '0;
      if (bad)          err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_frame_collector.sv
// Directed bench for iq_frame_collector: per-cycle vector table plus
// hand-written reset-abort and negative-word sequences.
module tb_iq_frame_collector;

  localparam int RW = 20;
  localparam int NW = 8;
  localparam int CW = 16;
  localparam int FW = NW * RW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [RW-1:0] result_iq;
  logic                 strobe_cc;
  logic [FW-1:0]        frame_data;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [CW-1:0]        frame_count;
  logic [CW-1:0]        drop_count;
  logic                 err_len;
  logic                 err_clr;

  int total = 0;
  int bad   = 0;

  iq_frame_collector #(.rw(RW), .nw(NW), .cw(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .result_iq  (result_iq),
    .strobe_cc  (strobe_cc),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_count(frame_count),
    .drop_count (drop_count),
    .err_len    (err_len),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic [RW-1:0] d;
    logic          rdy;
    logic          clr;
    logic          ev;
    int            efc;
    int            edc;
    logic          eerr;
    logic          chk;
    logic [FW-1:0] efd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic st, input int d, input logic rdy, input logic clr,
                              input logic ev, input int efc, input int edc, input logic eerr,
                              input logic chk, input logic [FW-1:0] efd);
    vec_t v;
    v.st = st; v.d = d[RW-1:0]; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.efc = efc; v.edc = edc; v.eerr = eerr; v.chk = chk; v.efd = efd;
    tbl.push_back(v);
  endfunction

  function automatic logic [FW-1:0] frame(input int first);
    logic [FW-1:0] f;
    int w;
    f = '0;
    for (int k = 0; k < NW; k++) begin
      w = first + k;
      f[k*RW +: RW] = w[RW-1:0];
    end
    return f;
  endfunction

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic ev, input int efc, input int edc, input logic eerr);
    check({nm, " valid"}, FW'(frame_valid), FW'(ev));
    check({nm, " fcount"}, FW'(frame_count), FW'(efc));
    check({nm, " dcount"}, FW'(drop_count), FW'(edc));
    check({nm, " errlen"}, FW'(err_len), FW'(eerr));
  endtask

  task automatic build_table();
    // single frame, consumer always ready
    for (int k = 1; k <= 8; k++) add(1, k, 1, 0, 0, 0, 0, 0, 0, '0);
    add(0, 0, 1, 0, 1, 1, 0, 0, 1, frame(1));
    add(0, 0, 1, 0, 0, 1, 0, 0, 0, '0);
    // two frames with consumer stalled: second is dropped
    for (int k = 0; k < 8; k++) add(1, 11 + k, 0, 0, 0, 1, 0, 0, 0, '0);
    add(0, 0, 0, 0, 1, 2, 0, 0, 1, frame(11));
    for (int k = 0; k < 8; k++) add(1, 21 + k, 0, 0, 1, 2, 0, 0, 1, frame(11));
    add(0, 0, 0, 0, 1, 2, 1, 0, 1, frame(11));
    add(0, 0, 1, 0, 0, 2, 1, 0, 0, '0);
    // short, long and very long runs, each followed by err_clr
    for (int k = 0; k < 7; k++) add(1, 31 + k, 0, 0, 0, 2, 1, 0, 0, '0);
    add(0, 0, 0, 0, 0, 2, 1, 1, 0, '0);
    add(0, 0, 0, 1, 0, 2, 0, 0, 0, '0);
    for (int k = 0; k < 9; k++) add(1, 31 + k, 0, 0, 0, 2, 0, 0, 0, '0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0, '0);
    add(0, 0, 0, 1, 0, 2, 0, 0, 0, '0);
    for (int k = 0; k < 24; k++) add(1, 100 + k, 0, 0, 0, 2, 0, 0, 0, '0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0, '0);
    add(0, 0, 0, 1, 0, 2, 0, 0, 0, '0);
    // err_clr coinciding with a drop and with a length error
    for (int k = 0; k < 8; k++) add(1, 41 + k, 0, 0, 0, 2, 0, 0, 0, '0);
    add(0, 0, 0, 0, 1, 3, 0, 0, 1, frame(41));
    for (int k = 0; k < 8; k++) add(1, 51 + k, 0, 0, 1, 3, 0, 0, 0, '0);
    add(0, 0, 0, 0, 1, 3, 1, 0, 1, frame(41));
    for (int k = 0; k < 8; k++) add(1, 61 + k, 0, 0, 1, 3, 1, 0, 0, '0);
    add(0, 0, 0, 1, 1, 3, 1, 0, 1, frame(41));
    for (int k = 0; k < 3; k++) add(1, 5, 0, 0, 1, 3, 1, 0, 0, '0);
    add(0, 0, 0, 1, 1, 3, 0, 1, 1, frame(41));
    // new frame lands on the same edge the held one is consumed
    for (int k = 0; k < 8; k++) add(1, 71 + k, 0, 0, 1, 3, 0, 1, 1, frame(41));
    add(0, 0, 1, 0, 1, 4, 0, 1, 1, frame(71));
    add(0, 0, 1, 0, 0, 4, 0, 1, 0, '0);
  endtask

  logic signed [RW-1:0] neg_words [NW];
  logic [FW-1:0]        neg_exp;

  initial begin
    reset = 1'b1; strobe_cc = 1'b0; result_iq = '0; frame_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset fdata", frame_data, '0);
    check_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      strobe_cc = tbl[i].st; result_iq = tbl[i].d; frame_ready = tbl[i].rdy; err_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), tbl[i].ev, tbl[i].efc, tbl[i].edc, tbl[i].eerr);
      if (tbl[i].chk) check($sformatf("v%0d fdata", i), frame_data, tbl[i].efd);
    end

    // extreme negative and positive words keep their exact bit patterns
    neg_words = '{-20'sd524288, -20'sd1, 20'sd0, 20'sd1, 20'sd524287, -20'sd2, 20'sd12345, -20'sd12345};
    neg_exp = {20'hFCFC7, 20'h03039, 20'hFFFFE, 20'h7FFFF, 20'h00001, 20'h00000, 20'hFFFFF, 20'h80000};
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      strobe_cc = 1'b1; result_iq = neg_words[k]; frame_ready = 1'b1; err_clr = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    strobe_cc = 1'b0; result_iq = '0;
    @(posedge clk);
    #1;
    check("neg fdata", frame_data, neg_exp);
    check_all("neg end", 1, 5, 0, 1);
    @(posedge clk);
    #1;
    check("neg consumed valid", FW'(frame_valid), FW'(0));

    // reset in the middle of a run aborts it; the remainder is a short frame
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      strobe_cc = 1'b1; result_iq = RW'(k); frame_ready = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset fdata", frame_data, '0);
    check_all("midreset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("midreset hold", 0, 0, 0, 0);
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      reset = 1'b0; strobe_cc = 1'b1; result_iq = RW'(k);
      @(posedge clk);
    end
    @(negedge clk);
    strobe_cc = 1'b0;
    @(posedge clk);
    #1;
    check_all("after abort", 0, 0, 0, 1);
    check("after abort fdata", frame_data, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
